reg_access_ctrl: RTL and testbench
==================================

Name: reg_access_ctrl

Overview:
- Initiator-side controller for the 16 x 32-bit dual-port register file.
- Accepts operand-fetch requests from decode and writeback results from execute.
- Drives both register-file ports, reading operands or committing results each cycle.
- Tracks in-flight destinations in a scoreboard and stalls on hazards.

Parameters:
WORD_SIZE, 32, data width
NUM_REGS, 16, register count
ADDR_W, 4, register address width (log2 NUM_REGS)
WBQ_DEPTH, 2, writeback queue entries (legal 2..8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_valid  in  1  issue request valid
iss_ready  out  1  issue accepted this cycle when high with iss_valid
iss_rs0  in  ADDR_W  source register A
iss_rs1  in  ADDR_W  source register B
iss_rd  in  ADDR_W  destination register
iss_rd_en  in  1  instruction writes iss_rd
op_valid  out  1  operand pair valid
op_ready  in  1  consumer takes operands
op_a  out  WORD_SIZE  value of rs0
op_b  out  WORD_SIZE  value of rs1
wb_valid  in  1  writeback valid
wb_ready  out  1  writeback queue not full
wb_rd  in  ADDR_W  writeback destination
wb_data  in  WORD_SIZE  writeback value
wb_err  out  1  one-cycle pulse: writeback to non-busy register
rf_addr0  out  ADDR_W  register-file port 0 address
rf_din0  out  WORD_SIZE  port 0 write data
rf_we0  out  1  port 0 write enable
rf_dout0  in  WORD_SIZE  port 0 read data, combinational
rf_addr1  out  ADDR_W  port 1 address
rf_din1  out  WORD_SIZE  port 1 write data
rf_we1  out  1  port 1 write enable
rf_dout1  in  WORD_SIZE  port 1 read data, combinational

Behaviour:
- Reset (sync, clk edge with rst=1):
  - scoreboard, queue, op_valid, wb_err cleared; op_a/op_b = 0.
  - rf_we0/rf_we1 low during and after reset until a write is granted.
  - Register-file contents are not touched.
- Scoreboard: NUM_REGS busy bits.
  - Set on issue acceptance when iss_rd_en.
  - Cleared in the cycle the write for that register is committed (rf_weN high).
- Hazard: issue is blocked if busy[rs0], busy[rs1], or (iss_rd_en and busy[rd]).
  - Hazard checks use the registered busy bits: a commit does not unblock an issue until the following cycle.
- Output slot free = !op_valid || op_ready.
- Port grant, one mode per cycle, combinational:
  - WRITE if queue count == WBQ_DEPTH.
  - else READ if iss_valid, no hazard, and output slot free.
  - else WRITE if queue nonempty.
  - else IDLE.
- READ:
  - rf_addr0=rs0, rf_addr1=rs1, both we low; iss_ready=1.
  - Next edge: op_a<=rf_dout0, op_b<=rf_dout1, op_valid<=1.
  - Latency: issue acceptance to op_valid = 1 cycle.
- WRITE:
  - Oldest entry on port 0, second-oldest on port 1 if present; up to 2 commits per cycle.
  - Corresponding busy bits cleared; entries popped.
  - The scoreboard makes both entries distinct registers; no same-address double write.
- iss_ready=0 in WRITE and IDLE.
- op_valid stays high, op_a/op_b stable, until op_ready. op_valid falls the cycle after a handshake with no new READ.
- Queue:
  - wb_ready = count < WBQ_DEPTH.
  - Push on wb_valid && wb_ready.
  - Push and pop in the same cycle are allowed; count updates by pushes minus pops.
  - A pushed entry is not drained in its push cycle.
- wb_err:
  - Pulses the cycle after a push whose wb_rd is not busy.
  - The entry is still queued and written; no busy bit changes.
- Simultaneous issue and push of the same register: the issue hazard check uses pre-push busy state.
- Reset mid-operation:
  - All pending writebacks and any held operands are dropped.
  - Upstream must also be reset.

Test Plan:
- Reset, then rf holds r3=0x11, r5=0x22; issue rs0=3, rs1=5, rd_en=0 -> READ grant, op_valid next cycle, op_a=0x11, op_b=0x22.
- Issue rd=7 rd_en=1, then issue rs0=7 -> second issue stalled (iss_ready=0); push wb r7=0xDEAD -> committed on port 0 next cycle; issue accepted the cycle after; op_a=0xDEAD.
- Busy r1,r2; push wb r1=0xA and r2=0xB with iss_valid held, no hazard on it -> READ wins until queue full, then single WRITE cycle with rf_we0=rf_we1=1 committing both.
- Hold op_ready=0 with op_valid=1, new non-hazard issue pending -> iss_ready=0, op_a/op_b unchanged; raise op_ready -> issue accepted same cycle, new operands next cycle.
- Push wb to r9 while r9 not busy -> wb_err pulses one cycle, r9 still written.
- Assert rst while queue holds 2 entries and op_valid=1 -> next cycle count=0, op_valid=0, all busy clear, no rf_we asserted.

Source files
------------

// File: rtl/reg_access_ctrl_if.sv
// Bundle between reg_access_ctrl and its neighbours:
// issue/operand path, writeback path and both register-file ports.
interface reg_access_ctrl_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 4
);
    logic                 iss_valid;
    logic                 iss_ready;
    logic [ADDR_W-1:0]    iss_rs0;
    logic [ADDR_W-1:0]    iss_rs1;
    logic [ADDR_W-1:0]    iss_rd;
    logic                 iss_rd_en;

    logic                 op_valid;
    logic                 op_ready;
    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [ADDR_W-1:0]    wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic                 wb_err;

    logic [ADDR_W-1:0]    rf_addr0;
    logic [WORD_SIZE-1:0] rf_din0;
    logic                 rf_we0;
    logic [WORD_SIZE-1:0] rf_dout0;
    logic [ADDR_W-1:0]    rf_addr1;
    logic [WORD_SIZE-1:0] rf_din1;
    logic                 rf_we1;
    logic [WORD_SIZE-1:0] rf_dout1;

    modport slave (
        input  iss_valid, iss_rs0, iss_rs1, iss_rd, iss_rd_en,
        output iss_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready, wb_err,
        output rf_addr0, rf_din0, rf_we0,
        input  rf_dout0,
        output rf_addr1, rf_din1, rf_we1,
        input  rf_dout1
    );

    modport master (
        output iss_valid, iss_rs0, iss_rs1, iss_rd, iss_rd_en,
        input  iss_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready, wb_err,
        input  rf_addr0, rf_din0, rf_we0,
        output rf_dout0,
        input  rf_addr1, rf_din1, rf_we1,
        output rf_dout1
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register-file access controller: operand reads, queued writeback
// commits on both ports, and a busy scoreboard for hazard stalls.
module reg_access_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = 4,
    parameter int WBQ_DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    reg_access_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(WBQ_DEPTH);
    localparam int CNT_W = $clog2(WBQ_DEPTH + 1);

    typedef enum logic [1:0] {
        M_IDLE,
        M_READ,
        M_WRITE
    } mode_t;

    mode_t                mode;
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_n;
    logic [ADDR_W-1:0]    q_rd   [WBQ_DEPTH];
    logic [WORD_SIZE-1:0] q_data [WBQ_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     head1;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic                 op_valid;
    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;
    logic                 wb_err;

    logic hazard;
    logic full;
    logic slot_free;
    logic push;
    logic pop1;
    logic pop2;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign hazard = busy[bus.iss_rs0] | busy[bus.iss_rs1]
                  | (bus.iss_rd_en & busy[bus.iss_rd]);
    assign full      = (count == CNT_W'(WBQ_DEPTH));
    assign slot_free = !op_valid || bus.op_ready;
    assign head1     = nxt(head);
    assign push      = bus.wb_valid && bus.wb_ready;
    assign pop1      = (mode == M_WRITE);
    assign pop2      = pop1 && (count >= CNT_W'(2));

    // A full queue pre-empts reads so writebacks can never starve.
    always_comb begin
        mode = M_IDLE;
        if (rst)
            mode = M_IDLE;
        else if (full)
            mode = M_WRITE;
        else if (bus.iss_valid && !hazard && slot_free)
            mode = M_READ;
        else if (count != '0)
            mode = M_WRITE;
    end

    always_comb begin
        bus.iss_ready = 1'b0;
        bus.rf_addr0  = '0;
        bus.rf_addr1  = '0;
        bus.rf_din0   = '0;
        bus.rf_din1   = '0;
        bus.rf_we0    = 1'b0;
        bus.rf_we1    = 1'b0;
        unique case (mode)
            M_READ: begin
                bus.iss_ready = 1'b1;
                bus.rf_addr0  = bus.iss_rs0;
                bus.rf_addr1  = bus.iss_rs1;
            end
            M_WRITE: begin
                bus.rf_we0   = 1'b1;
                bus.rf_addr0 = q_rd[head];
                bus.rf_din0  = q_data[head];
                if (pop2) begin
                    bus.rf_we1   = 1'b1;
                    bus.rf_addr1 = q_rd[head1];
                    bus.rf_din1  = q_data[head1];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_n = busy;
        if (pop1)
            busy_n[q_rd[head]] = 1'b0;
        if (pop2)
            busy_n[q_rd[head1]] = 1'b0;
        if (mode == M_READ && bus.iss_rd_en)
            busy_n[bus.iss_rd] = 1'b1;
    end

    assign bus.wb_ready = !full;
    assign bus.wb_err   = wb_err;
    assign bus.op_valid = op_valid;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;

    // Queue storage needs no reset; head/tail/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= bus.wb_rd;
            q_data[tail] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy   <= busy_n;
            wb_err <= push && !busy[bus.wb_rd];
            if (push)
                tail <= nxt(tail);
            if (pop2)
                head <= nxt(head1);
            else if (pop1)
                head <= head1;
            count <= count + CNT_W'(push) - CNT_W'(pop1) - CNT_W'(pop2);
            if (mode == M_READ) begin
                op_valid <= 1'b1;
                op_a     <= bus.rf_dout0;
                op_b     <= bus.rf_dout1;
            end else if (bus.op_ready) begin
                op_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl: directed scenarios, then
// randomized issue/writeback traffic against a register-value model.
module tb_reg_access_ctrl;
    localparam int WS    = 32;
    localparam int NR    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [WS-1:0] data;
    } wb_t;

    typedef struct packed {
        logic [WS-1:0] a;
        logic [WS-1:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_access_ctrl_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

    reg_access_ctrl #(
        .WORD_SIZE(WS), .NUM_REGS(NR), .ADDR_W(AW), .WBQ_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic abort      = 1'b0;
    logic rand_phase = 1'b0;
    logic iss_done   = 1'b0;
    logic rf_init    = 1'b1;

    function automatic logic [WS-1:0] init_val(input int i);
        if (i == 3) return 32'h11;
        if (i == 5) return 32'h22;
        return 32'hC0DE_0000 | WS'(i);
    endfunction

    // Register file modelled as combinational-read, clocked-write memory.
    logic [WS-1:0] rf_mem [NR];
    assign bus.rf_dout0 = rf_mem[bus.rf_addr0];
    assign bus.rf_dout1 = rf_mem[bus.rf_addr1];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < NR; i++) rf_mem[i] <= init_val(i);
        end else begin
            if (bus.rf_we0) rf_mem[bus.rf_addr0] <= bus.rf_din0;
            if (bus.rf_we1) rf_mem[bus.rf_addr1] <= bus.rf_din1;
        end
    end

    task automatic chk(input string nm, input logic [WS-1:0] got,
                       input logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Scoreboard state: pushed-but-uncommitted writebacks, expected
    // operands, and the architectural value of every register.
    wb_t           pend   [$];
    op_t           exp_op [$];
    logic [WS-1:0] ref_val [NR];
    logic          prev_acc = 1'b0;
    wb_t           m_w;
    op_t           m_o;

    initial begin
        for (int i = 0; i < NR; i++) ref_val[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("we_in_reset", {30'd0, bus.rf_we1, bus.rf_we0}, 32'd0);
                pend.delete();
                exp_op.delete();
                prev_acc = 1'b0;
            end else begin
                if (prev_acc) chk("op_latency", {31'd0, bus.op_valid}, 32'd1);
                if (bus.op_valid && bus.op_ready) begin
                    if (exp_op.size() == 0) begin
                        fail_now("op_unexpected");
                    end else begin
                        m_o = exp_op.pop_front();
                        chk("op_a", bus.op_a, m_o.a);
                        chk("op_b", bus.op_b, m_o.b);
                    end
                end
                if (bus.rf_we0) begin
                    if (pend.size() == 0) begin
                        fail_now("commit0_unexpected");
                    end else begin
                        m_w = pend.pop_front();
                        chk("commit0_rd", WS'(bus.rf_addr0), WS'(m_w.rd));
                        chk("commit0_data", bus.rf_din0, m_w.data);
                        ref_val[m_w.rd] = m_w.data;
                    end
                end
                if (bus.rf_we1) begin
                    if (pend.size() == 0) begin
                        fail_now("commit1_unexpected");
                    end else begin
                        m_w = pend.pop_front();
                        chk("commit1_rd", WS'(bus.rf_addr1), WS'(m_w.rd));
                        chk("commit1_data", bus.rf_din1, m_w.data);
                        ref_val[m_w.rd] = m_w.data;
                    end
                end
                prev_acc = bus.iss_valid && bus.iss_ready;
                if (prev_acc) begin
                    m_o.a = ref_val[bus.iss_rs0];
                    m_o.b = ref_val[bus.iss_rs1];
                    exp_op.push_back(m_o);
                end
                if (bus.wb_valid && bus.wb_ready) begin
                    m_w.rd   = bus.wb_rd;
                    m_w.data = bus.wb_data;
                    pend.push_back(m_w);
                end
                if (rand_phase) chk("wb_err_spurious", {31'd0, bus.wb_err}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rd, input logic en);
        bus.iss_rs0   = rs0;
        bus.iss_rs1   = rs1;
        bus.iss_rd    = rd;
        bus.iss_rd_en = en;
        bus.iss_valid = 1'b1;
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [WS-1:0] d);
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        bus.wb_valid = 1'b1;
    endtask

    task automatic wait_acc(input string nm);
        int t = 0;
        @(negedge clk);
        while (!bus.iss_ready && t < 400 && !abort) begin
            @(negedge clk);
            t++;
        end
        if (!bus.iss_ready && !abort) begin
            fail_now(nm);
            abort = 1'b1;
        end
    endtask

    task automatic wait_wb(input string nm);
        int t = 0;
        @(negedge clk);
        while (!bus.wb_ready && t < 400 && !abort) begin
            @(negedge clk);
            t++;
        end
        if (!bus.wb_ready && !abort) begin
            fail_now(nm);
            abort = 1'b1;
        end
    endtask

    logic [AW-1:0] owed [$];
    logic [AW-1:0] r_rs0, r_rs1, r_rd;
    logic          r_en;
    int            r_k;

    initial begin
        bus.iss_valid = 1'b0;
        bus.iss_rs0   = '0;
        bus.iss_rs1   = '0;
        bus.iss_rd    = '0;
        bus.iss_rd_en = 1'b0;
        bus.op_ready  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rf_init = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("rst_wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
        cyc();

        // Plain operand read
        issue(3, 5, 0, 1'b0);
        @(negedge clk); chk("t1_ready", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); bus.iss_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("t1_op_a", bus.op_a, 32'h11);
        chk("t1_op_b", bus.op_b, 32'h22);
        cyc(); bus.op_ready = 1'b1;
        cyc();
        @(negedge clk); chk("t1_drop", {31'd0, bus.op_valid}, 32'd0);
        cyc();

        // RAW stall released by a writeback commit
        issue(0, 0, 7, 1'b1);
        @(negedge clk); chk("t2_acc", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(7, 0, 0, 1'b0);
        @(negedge clk); chk("t2_stall", {31'd0, bus.iss_ready}, 32'd0);
        cyc(); wb(7, 32'hDEAD);
        @(negedge clk);
        chk("t2_stall2", {31'd0, bus.iss_ready}, 32'd0);
        chk("t2_wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        cyc(); bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t2_we0", {31'd0, bus.rf_we0}, 32'd1);
        chk("t2_addr0", WS'(bus.rf_addr0), 32'd7);
        chk("t2_din0", bus.rf_din0, 32'hDEAD);
        chk("t2_stall3", {31'd0, bus.iss_ready}, 32'd0);
        cyc();
        @(negedge clk); chk("t2_acc2", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); bus.iss_valid = 1'b0;
        @(negedge clk); chk("t2_op_a", bus.op_a, 32'hDEAD);
        cyc();

        // Reads win until the queue fills, then a dual commit
        issue(0, 0, 1, 1'b1);
        @(negedge clk); chk("t3_acc1", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(0, 0, 2, 1'b1);
        @(negedge clk); chk("t3_acc2", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(3, 5, 0, 1'b0); wb(1, 32'hA);
        @(negedge clk);
        chk("t3_read0", {31'd0, bus.iss_ready}, 32'd1);
        chk("t3_nowe0", {31'd0, bus.rf_we0}, 32'd0);
        cyc(); wb(2, 32'hB);
        @(negedge clk);
        chk("t3_read1", {31'd0, bus.iss_ready}, 32'd1);
        chk("t3_nowe1", {31'd0, bus.rf_we0}, 32'd0);
        cyc(); bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t3_full", {31'd0, bus.wb_ready}, 32'd0);
        chk("t3_blocked", {31'd0, bus.iss_ready}, 32'd0);
        chk("t3_we", {30'd0, bus.rf_we1, bus.rf_we0}, 32'd3);
        chk("t3_addr0", WS'(bus.rf_addr0), 32'd1);
        chk("t3_addr1", WS'(bus.rf_addr1), 32'd2);
        chk("t3_din0", bus.rf_din0, 32'hA);
        chk("t3_din1", bus.rf_din1, 32'hB);
        cyc();
        @(negedge clk); chk("t3_resume", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); bus.iss_valid = 1'b0;
        cyc(); cyc();

        // Output back-pressure
        bus.op_ready = 1'b0;
        issue(3, 5, 0, 1'b0);
        @(negedge clk); chk("t4_acc", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(1, 2, 0, 1'b0);
        @(negedge clk);
        chk("t4_block", {31'd0, bus.iss_ready}, 32'd0);
        chk("t4_hold_a", bus.op_a, 32'h11);
        cyc();
        @(negedge clk);
        chk("t4_block2", {31'd0, bus.iss_ready}, 32'd0);
        chk("t4_hold_a2", bus.op_a, 32'h11);
        chk("t4_hold_b2", bus.op_b, 32'h22);
        cyc(); bus.op_ready = 1'b1;
        @(negedge clk); chk("t4_go", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); bus.iss_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid", {31'd0, bus.op_valid}, 32'd1);
        chk("t4_op_a", bus.op_a, 32'hA);
        chk("t4_op_b", bus.op_b, 32'hB);
        cyc(); cyc();

        // Writeback to a register nobody owns
        wb(9, 32'h99);
        @(negedge clk); chk("t5_err_pre", {31'd0, bus.wb_err}, 32'd0);
        cyc(); bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("t5_err", {31'd0, bus.wb_err}, 32'd1);
        chk("t5_we0", {31'd0, bus.rf_we0}, 32'd1);
        chk("t5_addr0", WS'(bus.rf_addr0), 32'd9);
        cyc();
        @(negedge clk);
        chk("t5_err_post", {31'd0, bus.wb_err}, 32'd0);
        chk("t5_rf9", rf_mem[9], 32'h99);
        cyc();

        // Reset with a full queue and a held operand pair
        issue(0, 0, 4, 1'b1);
        @(negedge clk); chk("t6_acc1", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); issue(0, 0, 6, 1'b1);
        @(negedge clk); chk("t6_acc2", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); bus.iss_valid = 1'b0; wb(4, 32'h4444);
        cyc(); wb(6, 32'h6666); issue(0, 0, 0, 1'b0);
        @(negedge clk); chk("t6_read", {31'd0, bus.iss_ready}, 32'd1);
        cyc();
        bus.wb_valid  = 1'b0;
        bus.iss_valid = 1'b0;
        bus.op_ready  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_full", {31'd0, bus.wb_ready}, 32'd0);
        chk("t6_held", {31'd0, bus.op_valid}, 32'd1);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("t6_cnt0", {31'd0, bus.wb_ready}, 32'd1);
        chk("t6_opv0", {31'd0, bus.op_valid}, 32'd0);
        chk("t6_we", {30'd0, bus.rf_we1, bus.rf_we0}, 32'd0);
        chk("t6_op_a0", bus.op_a, 32'd0);
        cyc();
        bus.op_ready = 1'b1;
        issue(4, 6, 0, 1'b0);
        @(negedge clk); chk("t6_notbusy", {31'd0, bus.iss_ready}, 32'd1);
        cyc(); bus.iss_valid = 1'b0;
        cyc(); cyc();
        chk("t6_rf4", rf_mem[4], init_val(4));

        // Randomized traffic
        rand_phase = 1'b1;
        fork
            begin
                for (int n = 0; n < 300 && !abort; n++) begin
                    if ($urandom_range(0, 3) == 0) cyc();
                    r_rs0 = AW'($urandom_range(0, NR - 1));
                    r_rs1 = AW'($urandom_range(0, NR - 1));
                    r_rd  = AW'($urandom_range(0, NR - 1));
                    r_en  = 1'($urandom_range(0, 1));
                    issue(r_rs0, r_rs1, r_rd, r_en);
                    wait_acc("iss_timeout");
                    if (r_en && !abort) owed.push_back(r_rd);
                    cyc();
                    bus.iss_valid = 1'b0;
                end
                iss_done = 1'b1;
            end
            begin
                while ((!iss_done || owed.size() != 0) && !abort) begin
                    if (owed.size() != 0 && $urandom_range(0, 2) == 0) begin
                        r_k = $urandom_range(0, owed.size() - 1);
                        wb(owed[r_k], $urandom);
                        owed.delete(r_k);
                        wait_wb("wb_timeout");
                        cyc();
                        bus.wb_valid = 1'b0;
                    end else begin
                        cyc();
                    end
                end
            end
            begin
                while (!iss_done && !abort) begin
                    bus.op_ready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
                bus.op_ready = 1'b1;
            end
        join
        bus.iss_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.op_ready  = 1'b1;
        repeat (10) cyc();
        rand_phase = 1'b0;

        chk("end_pend", pend.size(), 32'd0);
        chk("end_ops", exp_op.size(), 32'd0);
        for (int i = 0; i < NR; i++) chk("end_rf", rf_mem[i], ref_val[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
